// File: rtl/ns_logic.sv
// ---------------------------------------------------------------------------
// ns_logic -- next-state logic for the two-street traffic-light controller.
//
// State encoding {q1,q0}:
//   00 S0  A green / B red      01 S1  A yellow
//   10 S2  B green / A red      11 S3  B yellow
//
// Ports:
//   clk    in   rising-edge clock for ns_q / trans (and the dwell counter)
//   reset  in   asynchronous, active-high; clears ns_q, trans, dwell counter
//   Ta     in   street-A traffic sensor (1 = traffic present)
//   Tb     in   street-B traffic sensor (1 = traffic present)
//   q1,q0  in   present state from the controller's state register
//   d1,d0  out  next state, purely combinational
//   ns_q   out  registered {d1,d0}
//   trans  out  registered flag: sampled next state != sampled present state
//
// Parameter:
//   MIN_GREEN  minimum green dwell in clock cycles (1..255); only has an
//              effect when the optional feature is built in.
//
// Optional feature, macro TL_MIN_GREEN_EN:
//   Adds an 8-bit dwell counter that counts cycles spent in a green state
//   (saturating at MIN_GREEN) and clears in the yellow states. A green state
//   may only be left once the counter has reached MIN_GREEN.
// ---------------------------------------------------------------------------
module ns_logic #(
    parameter int MIN_GREEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Ta,
    input  logic       Tb,
    input  logic       q1,
    input  logic       q0,
    output logic       d1,
    output logic       d0,
    output logic [1:0] ns_q,
    output logic       trans
);

    // Elaboration-time guard on the dwell length.
    if (MIN_GREEN < 1 || MIN_GREEN > 255) begin : g_bad_min_green
        $error("ns_logic: MIN_GREEN must be in 1..255");
    end

    logic [1:0] ns_d;
    logic [1:0] ns_r_q;
    logic       trans_d;
    logic       trans_q;

`ifdef TL_MIN_GREEN_EN
    localparam logic [7:0] MIN_GREEN_C = 8'(MIN_GREEN);

    logic [7:0] cnt_d;
    logic [7:0] cnt_q;
    logic       green;
    logic       done;

    always_comb begin
        // q0 == 0 marks the two green states (S0, S2).
        green = ~q0;
        done  = (cnt_q >= MIN_GREEN_C);

        // Green states hold (d1 = q1) until released; yellows advance.
        d1 = green ? q1 : (q1 ^ q0);
        d0 = (~q1 & ~q0 & ~Ta & done) | (q1 & ~q0 & ~Tb & done);

        // Count dwell in green, saturating once the minimum is reached;
        // yellow states restart the count for the next green.
        if (!green) begin
            cnt_d = 8'd0;
        end else if (done) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        d1 = q1 ^ q0;
        d0 = (~q1 & ~q0 & ~Ta) | (q1 & ~q0 & ~Tb);
    end
`endif

    always_comb begin
        ns_d    = {d1, d0};
        trans_d = (ns_d != {q1, q0});
    end

    // Register stage: debug/state-register copy of the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ns_r_q  <= 2'b00;
            trans_q <= 1'b0;
        end else begin
            ns_r_q  <= ns_d;
            trans_q <= trans_d;
        end
    end

    assign ns_q  = ns_r_q;
    assign trans = trans_q;

endmodule

// File: tb/tb_ns_logic.sv
// ---------------------------------------------------------------------------
// tb_ns_logic -- directed, table-driven bench for ns_logic.
// The default build exercises the base equations and registers; building
// with TL_MIN_GREEN_EN exercises the green-dwell behaviour (MIN_GREEN = 4).
// ---------------------------------------------------------------------------
module tb_ns_logic;

    logic       clk;
    logic       reset;
    logic       Ta;
    logic       Tb;
    logic       q1;
    logic       q0;
    logic       d1;
    logic       d0;
    logic [1:0] ns_q;
    logic       trans;

    int checks;
    int errors;

    ns_logic #(.MIN_GREEN(4)) dut (
        .clk   (clk),
        .reset (reset),
        .Ta    (Ta),
        .Tb    (Tb),
        .q1    (q1),
        .q0    (q0),
        .d1    (d1),
        .d0    (d0),
        .ns_q  (ns_q),
        .trans (trans)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] q;
        logic       ta;
        logic       tb;
        logic [1:0] exp_d;
        logic       exp_trans;
    } vec_t;

    task automatic check(input string name, input logic [1:0] actual,
                         input logic [1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, actual,
                     expected, $time);
        end
    endtask

    task automatic drive(input logic [1:0] q, input logic ta, input logic tb);
        q1 = q[1];
        q0 = q[0];
        Ta = ta;
        Tb = tb;
    endtask

    initial begin
        vec_t vecs[16];
        // Hand-computed from the state diagram: {q, Ta, Tb, d, trans}.
        vecs[0]  = '{2'b00, 1'b0, 1'b0, 2'b01, 1'b1};
        vecs[1]  = '{2'b00, 1'b0, 1'b1, 2'b01, 1'b1};
        vecs[2]  = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b0};
        vecs[3]  = '{2'b00, 1'b1, 1'b1, 2'b00, 1'b0};
        vecs[4]  = '{2'b01, 1'b0, 1'b0, 2'b10, 1'b1};
        vecs[5]  = '{2'b01, 1'b0, 1'b1, 2'b10, 1'b1};
        vecs[6]  = '{2'b01, 1'b1, 1'b0, 2'b10, 1'b1};
        vecs[7]  = '{2'b01, 1'b1, 1'b1, 2'b10, 1'b1};
        vecs[8]  = '{2'b10, 1'b0, 1'b0, 2'b11, 1'b1};
        vecs[9]  = '{2'b10, 1'b0, 1'b1, 2'b10, 1'b0};
        vecs[10] = '{2'b10, 1'b1, 1'b0, 2'b11, 1'b1};
        vecs[11] = '{2'b10, 1'b1, 1'b1, 2'b10, 1'b0};
        vecs[12] = '{2'b11, 1'b0, 1'b0, 2'b00, 1'b1};
        vecs[13] = '{2'b11, 1'b0, 1'b1, 2'b00, 1'b1};
        vecs[14] = '{2'b11, 1'b1, 1'b0, 2'b00, 1'b1};
        vecs[15] = '{2'b11, 1'b1, 1'b1, 2'b00, 1'b1};

        checks = 0;
        errors = 0;
        reset  = 1'b1;
        drive(2'b00, 1'b1, 1'b0);

        // Reset state while reset is held across a clock edge.
        @(posedge clk);
        #1;
        check("reset_ns_q", ns_q, 2'b00);
        check("reset_trans", {1'b0, trans}, 2'b00);

        @(negedge clk);
        reset = 1'b0;

`ifndef TL_MIN_GREEN_EN
        // S0 hold, Tb irrelevant.
        drive(2'b00, 1'b1, 1'b0);
        #1 check("s0_hold", {d1, d0}, 2'b00);
        drive(2'b00, 1'b1, 1'b1);
        #1 check("s0_hold_tb1", {d1, d0}, 2'b00);
        // S0 -> S1, S1 -> S2.
        drive(2'b00, 1'b0, 1'b1);
        #1 check("s0_to_s1", {d1, d0}, 2'b01);
        drive(2'b01, 1'b1, 1'b0);
        #1 check("s1_to_s2", {d1, d0}, 2'b10);
        // S2 hold and exit.
        drive(2'b10, 1'b0, 1'b1);
        #1 check("s2_hold", {d1, d0}, 2'b10);
        drive(2'b10, 1'b0, 1'b0);
        #1 check("s2_to_s3", {d1, d0}, 2'b11);
        // S3 -> S0.
        drive(2'b11, 1'b1, 1'b1);
        #1 check("s3_to_s0", {d1, d0}, 2'b00);

        // Full 16-combination sweep: combinational output, then registers.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i].q, vecs[i].ta, vecs[i].tb);
            #1 check($sformatf("sweep_d[%0d]", i), {d1, d0}, vecs[i].exp_d);
            @(posedge clk);
            #1;
            check($sformatf("sweep_ns_q[%0d]", i), ns_q, vecs[i].exp_d);
            check($sformatf("sweep_trans[%0d]", i), {1'b0, trans},
                  {1'b0, vecs[i].exp_trans});
        end

        // Register capture then asynchronous reset between edges.
        @(negedge clk);
        drive(2'b00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("reg_ns_q_01", ns_q, 2'b01);
        check("reg_trans_1", {1'b0, trans}, 2'b01);
        @(negedge clk);
        drive(2'b00, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("reg_ns_q_00", ns_q, 2'b00);
        check("reg_trans_0", {1'b0, trans}, 2'b00);

        @(negedge clk);
        drive(2'b10, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("pre_reset_ns_q", ns_q, 2'b11);
        #2 reset = 1'b1;
        #1;
        check("async_ns_q", ns_q, 2'b00);
        check("async_trans", {1'b0, trans}, 2'b00);
        check("reset_d_unaffected", {d1, d0}, 2'b11);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("resume_ns_q", ns_q, 2'b11);
        check("resume_trans", {1'b0, trans}, 2'b01);
`else
        // Green dwell in S0: held for 4 cycles, then released.
        drive(2'b00, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            #1 check($sformatf("mg_s0_cyc%0d", c), {d1, d0},
                     (c < 4) ? 2'b00 : 2'b01);
            @(negedge clk);
        end
        // S1 clears the counter and always advances.
        drive(2'b01, 1'b0, 1'b0);
        #1 check("mg_s1", {d1, d0}, 2'b10);
        @(negedge clk);
        // Green dwell in S2.
        drive(2'b10, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            #1 check($sformatf("mg_s2_cyc%0d", c), {d1, d0},
                     (c < 4) ? 2'b10 : 2'b11);
            @(negedge clk);
        end
        drive(2'b11, 1'b0, 1'b0);
        #1 check("mg_s3", {d1, d0}, 2'b00);
        @(posedge clk);
        #1;
        check("mg_ns_q", ns_q, 2'b00);
        check("mg_trans", {1'b0, trans}, 2'b01);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ns_logic.md
Name: ns_logic

Overview:
- Next-state logic for the two-street traffic-light controller (street A / street B).
- Computes the next state d[1:0] combinationally from the present state q[1:0] and the traffic sensors Ta and Tb.
- Also provides a registered copy of the next state and a transition flag, for the state register and for debug.
- Sits between the controller's state register and its output-decode logic.

Parameters:
- MIN_GREEN, 4, minimum number of clock cycles a green state is held. Used only when TL_MIN_GREEN_EN is defined. Legal range is 1..255.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- Ta  input  1  street-A traffic sensor; 1 = traffic present.
- Tb  input  1  street-B traffic sensor; 1 = traffic present.
- q1  input  1  present-state bit 1 (MSB).
- q0  input  1  present-state bit 0 (LSB).
- d1  output  1  next-state bit 1; combinational.
- d0  output  1  next-state bit 0; combinational.
- ns_q  output  2  registered {d1,d0}.
- trans  output  1  registered flag; 1 when the sampled next state differs from the sampled present state.

Behaviour:
- State encoding:
  - S0 = 00: A green, B red.
  - S1 = 01: A yellow.
  - S2 = 10: B green, A red.
  - S3 = 11: B yellow.
- Transitions (base build):
  - S0 stays in S0 while Ta=1; goes to S1 when Ta=0.
  - S1 always goes to S2.
  - S2 stays in S2 while Tb=1; goes to S3 when Tb=0.
  - S3 always goes to S0.
- Equations:
  - d1 = q1 XOR q0.
  - d0 = (~q1 & ~q0 & ~Ta) | (q1 & ~q0 & ~Tb).
- d1 and d0 are purely combinational: zero latency, no dependence on clk or reset, valid within the same delta as any input change.
- Don't-care inputs:
  - Tb is ignored in S0 and S1.
  - Ta is ignored in S2 and S3.
  - Both sensors are ignored in the yellow states S1 and S3.
- All four encodings are legal states; no illegal-state recovery is needed.
- ns_q:
  - On each rising clk edge, captures {d1,d0}.
  - Reset value is 2'b00 (S0).
- trans:
  - On each rising clk edge, captures ({d1,d0} != {q1,q0}).
  - Reset value is 0.
- Reset:
  - Asserting reset forces ns_q=00 and trans=0 immediately, without waiting for a clock edge.
  - Reset mid-operation does not affect d1/d0.
  - On the first rising edge after reset deasserts, the registers resume normal capture.
- Simultaneous sensor changes: only the sensor relevant to the present state matters, per the equations above.

Optional Feature:
- Macro: TL_MIN_GREEN_EN.
- Defined:
  - Adds an 8-bit green-dwell counter.
  - Asynchronous reset clears the counter to 0.
  - The counter increments each clk cycle while {q1,q0} is S0 or S2, saturating at MIN_GREEN.
  - It clears to 0 in S1 and S3.
  - The S0->S1 and S2->S3 transitions additionally require counter >= MIN_GREEN; until then the block holds the green state (d = q).
  - The equations become:
    - d0 = (~q1 & ~q0 & ~Ta & done) | (q1 & ~q0 & ~Tb & done), where done = (counter >= MIN_GREEN).
    - d1 = q1 XOR q0 in S1 and S3; d1 = q1 in S0 and S2.
- Not defined:
  - No counter is instantiated; the base equations apply exactly.
  - MIN_GREEN is unused.

Test Plan:
- S0 hold: q=00, Ta=1, Tb=0 -> d=00. Then Tb=1 (Ta=1) -> d stays 00.
- S0->S1 and S1->S2: q=00, Ta=0 -> d=01. Then q=01 with any Ta/Tb -> d=10.
- S2 hold and exit: q=10, Ta=0, Tb=1 -> d=10. Then Tb=0 -> d=11.
- S3->S0: q=11, Ta=1, Tb=1 -> d=00. Sweep all 16 input combinations against the equations.
- Registers and async reset:
  - With q=00, Ta=0, clock once -> ns_q=01, trans=1.
  - Hold q=00, Ta=1, clock -> ns_q=00, trans=0.
  - Assert reset between edges -> ns_q=00 and trans=0 immediately.
- TL_MIN_GREEN_EN, MIN_GREEN=4:
  - Hold q=00, Ta=0 -> d=00 for the first 4 cycles, then d=01.
  - Same check for q=10, Tb=0 -> d becomes 11 after 4 cycles.
